// File: rtl/colpar_pkg.sv
// -----------------------------------------------------------------------------
// colpar_pkg
// Shared definitions for the column-parity controller slice.
//   COLPAR_DEPTH    : lines per run (64). The controller ends a run on co_c64,
//                     not by counting lines itself.
//   COLPAR_WIDTH    : bits per line (25). Each line ends on co_c25.
//   COLPAR_WD_LIMIT : default watchdog limit. Must be larger than COLPAR_WIDTH
//                     so that a healthy line always carries out first.
//   colpar_state_e  : controller state encoding (3 bits).
//   colpar_is_busy  : true for every state that is part of an active run.
// -----------------------------------------------------------------------------
package colpar_pkg;

  localparam int unsigned COLPAR_DEPTH    = 64;
  localparam int unsigned COLPAR_WIDTH    = 25;
  localparam int unsigned COLPAR_WD_LIMIT = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_READ = 3'd2,
    S_BITS = 3'd3,
    S_SAVE = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } colpar_state_e;

  function automatic logic colpar_is_busy(input colpar_state_e s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/colpar_if.sv
// -----------------------------------------------------------------------------
// colpar_if
// Bundles the controller's handshake, datapath strobes and carry inputs.
//   master : the controller's view. It receives start/abort from the top level
//            and the two counter carries from the datapath, and drives the
//            datapath strobes plus the busy/done/err status.
//   slave  : the environment's view (top level + datapath), the mirror image.
// -----------------------------------------------------------------------------
interface colpar_if;

  // Control from the top level
  logic start;
  logic abort;
  // Carries from the datapath counters
  logic co_c64;
  logic co_c25;
  // Strobes to the datapath
  logic ld_fr;
  logic ld_r;
  logic en_fw;
  logic init0_c64;
  logic init0_c25;
  logic en_c64;
  logic en_c25;
  // Status to the top level
  logic busy;
  logic done;
  logic err;

  modport master (
    input  start, abort, co_c64, co_c25,
    output ld_fr, ld_r, en_fw, init0_c64, init0_c25, en_c64, en_c25,
    output busy, done, err
  );

  modport slave (
    output start, abort, co_c64, co_c25,
    input  ld_fr, ld_r, en_fw, init0_c64, init0_c25, en_c64, en_c25,
    input  busy, done, err
  );

endinterface

// File: rtl/colpar_watchdog.sv
// -----------------------------------------------------------------------------
// colpar_watchdog
// Saturating cycle counter used to catch a bit counter that never carries out.
//   clk     in  rising-edge clock
//   rst     in  asynchronous, active-high reset
//   clr_i   in  synchronous clear (has priority over en_i)
//   en_i    in  count this cycle
//   limit_o out count has reached WD_LIMIT-1
// The count holds at the limit instead of wrapping, so limit_o cannot drop
// back by itself while the owner is still deciding what to do with it.
// -----------------------------------------------------------------------------
module colpar_watchdog
  import colpar_pkg::*;
#(
  parameter int unsigned WD_LIMIT = COLPAR_WD_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  localparam int unsigned CNT_W = (WD_LIMIT > 1) ? $clog2(WD_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WD_LIMIT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign limit_o = (count_q == LAST);

  always_comb begin
    // NOTE: next-state defaults to the current value first, so every path
    // assigns count_d and no latch can be inferred.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !limit_o) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/colpar_controller.sv
// -----------------------------------------------------------------------------
// colpar_controller
// Sequences the column-parity datapath over 64 lines x 25 bits.
//   clk  in   rising-edge clock
//   rst  in   asynchronous, active-high reset (also resets the datapath)
//   bus  colpar_if.master
//        start/abort         : run control (abort always wins)
//        co_c64/co_c25       : datapath line/bit counter carries
//        ld_fr, ld_r, en_fw,
//        init0_c64/c25,
//        en_c64/c25          : datapath strobes
//        busy/done/err       : status
// Per line: READ (1 cycle) -> BITS (25 cycles, ends on co_c25, which is also
// the cycle that writes bit 24) -> SAVE (1 cycle, co_c64 ends the run).
// All outputs are Moore, decoded from the registered state only.
// WD_LIMIT must exceed the line width or healthy lines would trip the watchdog.
// -----------------------------------------------------------------------------
module colpar_controller
  import colpar_pkg::*;
#(
  parameter int unsigned WD_LIMIT = COLPAR_WD_LIMIT
) (
  input  logic     clk,
  input  logic     rst,
  colpar_if.master bus
);

  colpar_state_e state_q;
  colpar_state_e state_d;

  logic wd_clr;
  logic wd_en;
  logic wd_limit;

  // The watchdog only runs in S_BITS and restarts on every other state, so
  // each line gets its own budget.
  assign wd_en  = (state_q == S_BITS);
  assign wd_clr = (state_q != S_BITS);

  colpar_watchdog #(
    .WD_LIMIT (WD_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wd_clr),
    .en_i    (wd_en),
    .limit_o (wd_limit)
  );

  // Next-state logic. Carries are only looked at in the state that owns them.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_INIT;
        S_INIT: state_d = S_READ;
        S_READ: state_d = S_BITS;
        S_BITS: begin
          // A real carry beats a watchdog expiry in the same cycle.
          if (bus.co_c25)    state_d = S_SAVE;
          else if (wd_limit) state_d = S_ERR;
        end
        S_SAVE: state_d = bus.co_c64 ? S_DONE : S_READ;
        S_DONE: state_d = bus.start ? S_INIT : S_IDLE;
        S_ERR:  if (bus.start) state_d = S_INIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    bus.ld_fr     = 1'b0;
    bus.ld_r      = 1'b0;
    bus.en_fw     = 1'b0;
    bus.init0_c64 = 1'b0;
    bus.init0_c25 = 1'b0;
    bus.en_c64    = 1'b0;
    bus.en_c25    = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.busy      = colpar_is_busy(state_q);
    case (state_q)
      S_INIT: begin
        bus.init0_c64 = 1'b1;
        bus.init0_c25 = 1'b1;
      end
      S_READ: bus.ld_fr = 1'b1;
      S_BITS: begin
        bus.en_fw  = 1'b1;
        bus.en_c25 = 1'b1;
      end
      S_SAVE: begin
        // Bit counter is rearmed here so the next S_BITS starts at bit 0.
        bus.ld_r      = 1'b1;
        bus.en_c64    = 1'b1;
        bus.init0_c25 = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      S_ERR:   bus.err  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_colpar_controller.sv
// -----------------------------------------------------------------------------
// tb_colpar_controller
// Drives colpar_controller through a behavioural datapath (real line and bit
// counters) and compares strobe counts and event cycles against figures
// computed directly from the run geometry (lines, bits, per-line overhead).
// Cycle k of a run is the clock period that follows the edge accepting start.
// -----------------------------------------------------------------------------
module tb_colpar_controller;
  import colpar_pkg::*;

  localparam int DEPTH    = COLPAR_DEPTH;
  localparam int WIDTH    = COLPAR_WIDTH;
  localparam int WD_LIMIT = COLPAR_WD_LIMIT;
  // Cycle (relative to start acceptance) in which done is high.
  localparam int RUN_DONE = 1 + DEPTH * (1 + WIDTH + 1);
  localparam int TAIL     = 6;

  typedef struct packed {
    int en_fw;
    int ld_fr;
    int ld_r;
    int en_c64;
    int en_c25;
    int init64;
    int done;
    int done_cyc;
    int done_cyc2;
    int init64_cyc2;
    int err_cyc;
    int abort_cyc;
    int after_stop;
    bit last_busy;
    bit last_err;
  } counts_t;

  logic clk;
  logic rst;
  colpar_if bus ();

  int n_tests = 0;
  int n_fail  = 0;

  colpar_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath counters, cleared by the same reset as the DUT.
  int cnt_c64;
  int cnt_c25;
  bit force_c25_zero;
  bit force_c25_one;
  bit force_c64_one;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_c64 <= 0;
      cnt_c25 <= 0;
    end else begin
      if (bus.init0_c64)   cnt_c64 <= 0;
      else if (bus.en_c64) cnt_c64 <= cnt_c64 + 1;
      if (bus.init0_c25)   cnt_c25 <= 0;
      else if (bus.en_c25) cnt_c25 <= cnt_c25 + 1;
    end
  end

  assign bus.co_c25 = force_c25_one || (!force_c25_zero && (cnt_c25 == WIDTH - 1));
  assign bus.co_c64 = force_c64_one || (cnt_c64 == DEPTH - 1);

  function automatic logic [9:0] outs();
    return {bus.ld_fr, bus.ld_r, bus.en_fw, bus.init0_c64, bus.init0_c25,
            bus.en_c64, bus.en_c25, bus.busy, bus.done, bus.err};
  endfunction

  // Starts a run from the current negedge and observes max_cyc cycles.
  // ab_line/ab_bit >= 0 aborts during the S_BITS cycle writing that bit.
  // poke pulses start randomly while busy; start is held for k < hold_until.
  task automatic run_and_count(input int max_cyc, input int ab_line, input int ab_bit,
                               input bit poke, input int hold_until, output counts_t c);
    c = '0;
    c.done_cyc    = -1;
    c.done_cyc2   = -1;
    c.init64_cyc2 = -1;
    c.err_cyc     = -1;
    c.abort_cyc   = -1;
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < max_cyc; k++) begin
      if (c.abort_cyc >= 0 && outs() !== '0) c.after_stop++;
      if (bus.err && c.err_cyc < 0) c.err_cyc = k;
      if (c.err_cyc >= 0 && (bus.en_fw || bus.ld_fr || bus.ld_r)) c.after_stop++;
      if (bus.en_fw)  c.en_fw++;
      if (bus.ld_fr)  c.ld_fr++;
      if (bus.ld_r)   c.ld_r++;
      if (bus.en_c64) c.en_c64++;
      if (bus.en_c25) c.en_c25++;
      if (bus.init0_c64) begin
        c.init64++;
        if (k > 0 && c.init64_cyc2 < 0) c.init64_cyc2 = k;
      end
      if (bus.done) begin
        c.done++;
        if (c.done_cyc < 0) c.done_cyc = k;
        else if (c.done_cyc2 < 0) c.done_cyc2 = k;
      end
      bus.abort = 1'b0;
      if (ab_line >= 0 && c.abort_cyc < 0 && bus.en_fw &&
          cnt_c64 == ab_line && cnt_c25 == ab_bit) begin
        bus.abort   = 1'b1;
        c.abort_cyc = k;
      end
      bus.start   = (k < hold_until) || (poke && bus.busy && ($urandom_range(0, 2) == 0));
      c.last_busy = bus.busy;
      c.last_err  = bus.err;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    bit found;
    int bad;
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL reset.in_reset got %b exp 0", outs()); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL reset.idle got %b exp 0", outs()); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (bus.en_fw && cnt_c64 == 3 && cnt_c25 == 5) found = 1'b1;
      else @(negedge clk);
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL reset.reach_bits got 0 exp 1"); end
    rst = 1'b1;
    #1;
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL reset.async got %b exp 0", outs()); end
    @(negedge clk);
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL reset.next_cycle got %b exp 0", outs()); end
    rst = 1'b0;
    bad = 0;
    repeat (TAIL) begin
      @(negedge clk);
      if (outs() !== '0) bad++;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL reset.quiet_after got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_full_run(input bit poke, input string tag);
    counts_t c;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    run_and_count(RUN_DONE + TAIL, -1, -1, poke, 0, c);
    n_tests++; if (c.en_fw !== DEPTH * WIDTH) begin n_fail++; $display("FAIL %s.en_fw got %0d exp %0d", tag, c.en_fw, DEPTH * WIDTH); end
    n_tests++; if (c.en_c25 !== DEPTH * WIDTH) begin n_fail++; $display("FAIL %s.en_c25 got %0d exp %0d", tag, c.en_c25, DEPTH * WIDTH); end
    n_tests++; if (c.ld_fr !== DEPTH) begin n_fail++; $display("FAIL %s.ld_fr got %0d exp %0d", tag, c.ld_fr, DEPTH); end
    n_tests++; if (c.ld_r !== DEPTH) begin n_fail++; $display("FAIL %s.ld_r got %0d exp %0d", tag, c.ld_r, DEPTH); end
    n_tests++; if (c.en_c64 !== DEPTH) begin n_fail++; $display("FAIL %s.en_c64 got %0d exp %0d", tag, c.en_c64, DEPTH); end
    n_tests++; if (c.init64 !== 1) begin n_fail++; $display("FAIL %s.init0_c64 got %0d exp 1", tag, c.init64); end
    n_tests++; if (c.done !== 1) begin n_fail++; $display("FAIL %s.done_pulses got %0d exp 1", tag, c.done); end
    n_tests++; if (c.done_cyc !== RUN_DONE) begin n_fail++; $display("FAIL %s.done_cycle got %0d exp %0d", tag, c.done_cyc, RUN_DONE); end
    n_tests++; if (c.err_cyc !== -1) begin n_fail++; $display("FAIL %s.err got cycle %0d exp never", tag, c.err_cyc); end
    n_tests++; if (c.last_busy !== 1'b0) begin n_fail++; $display("FAIL %s.busy_end got %0b exp 0", tag, c.last_busy); end
  endtask

  task automatic test_back_to_back();
    counts_t c;
    run_and_count(2 * RUN_DONE + 1 + TAIL, -1, -1, 1'b0, RUN_DONE + 1, c);
    n_tests++; if (c.init64_cyc2 !== RUN_DONE + 1) begin n_fail++; $display("FAIL b2b.second_init got %0d exp %0d", c.init64_cyc2, RUN_DONE + 1); end
    n_tests++; if (c.en_fw !== 2 * DEPTH * WIDTH) begin n_fail++; $display("FAIL b2b.en_fw got %0d exp %0d", c.en_fw, 2 * DEPTH * WIDTH); end
    n_tests++; if (c.done !== 2) begin n_fail++; $display("FAIL b2b.done_pulses got %0d exp 2", c.done); end
    n_tests++; if (c.done_cyc !== RUN_DONE) begin n_fail++; $display("FAIL b2b.done1 got %0d exp %0d", c.done_cyc, RUN_DONE); end
    n_tests++; if (c.done_cyc2 !== 2 * RUN_DONE + 1) begin n_fail++; $display("FAIL b2b.done2 got %0d exp %0d", c.done_cyc2, 2 * RUN_DONE + 1); end
  endtask

  task automatic test_abort(input int line, input int bit_idx);
    counts_t c;
    int exp_fw;
    exp_fw = line * WIDTH + bit_idx + 1;
    run_and_count(RUN_DONE + TAIL, line, bit_idx, 1'b0, 0, c);
    n_tests++; if (c.abort_cyc < 0) begin n_fail++; $display("FAIL abort(%0d,%0d).reached got 0 exp 1", line, bit_idx); end
    n_tests++; if (c.en_fw !== exp_fw) begin n_fail++; $display("FAIL abort(%0d,%0d).en_fw got %0d exp %0d", line, bit_idx, c.en_fw, exp_fw); end
    n_tests++; if (c.ld_fr !== line + 1) begin n_fail++; $display("FAIL abort(%0d,%0d).ld_fr got %0d exp %0d", line, bit_idx, c.ld_fr, line + 1); end
    n_tests++; if (c.ld_r !== line) begin n_fail++; $display("FAIL abort(%0d,%0d).ld_r got %0d exp %0d", line, bit_idx, c.ld_r, line); end
    n_tests++; if (c.after_stop !== 0) begin n_fail++; $display("FAIL abort(%0d,%0d).activity_after got %0d exp 0", line, bit_idx, c.after_stop); end
    n_tests++; if (c.done !== 0) begin n_fail++; $display("FAIL abort(%0d,%0d).done got %0d exp 0", line, bit_idx, c.done); end
  endtask

  task automatic test_abort_start_collision();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL collision.idle got %b exp 0", outs()); end
    @(negedge clk);
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL collision.stay_idle got %b exp 0", outs()); end
  endtask

  task automatic test_watchdog();
    counts_t c;
    force_c25_zero = 1'b1;
    run_and_count(2 + WD_LIMIT + TAIL, -1, -1, 1'b0, 0, c);
    n_tests++; if (c.err_cyc !== 2 + WD_LIMIT) begin n_fail++; $display("FAIL wd.err_cycle got %0d exp %0d", c.err_cyc, 2 + WD_LIMIT); end
    n_tests++; if (c.en_fw !== WD_LIMIT) begin n_fail++; $display("FAIL wd.en_fw got %0d exp %0d", c.en_fw, WD_LIMIT); end
    n_tests++; if (c.after_stop !== 0) begin n_fail++; $display("FAIL wd.strobes_in_err got %0d exp 0", c.after_stop); end
    n_tests++; if (c.last_err !== 1'b1 || c.last_busy !== 1'b0) begin n_fail++; $display("FAIL wd.sticky got err=%0b busy=%0b exp err=1 busy=0", c.last_err, c.last_busy); end
    // abort leaves the error state
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_tests++; if (outs() !== '0) begin n_fail++; $display("FAIL wd.abort_clears got %b exp 0", outs()); end
    // trip again, then start clears err and runs normally
    run_and_count(2 + WD_LIMIT + TAIL, -1, -1, 1'b0, 0, c);
    n_tests++; if (c.last_err !== 1'b1) begin n_fail++; $display("FAIL wd.second_trip got %0b exp 1", c.last_err); end
    force_c25_zero = 1'b0;
    test_full_run(1'b0, "wd_restart");
  endtask

  task automatic test_out_of_state_carry();
    counts_t c;
    // co_c64 stuck high: only the first S_SAVE may act on it.
    force_c64_one = 1'b1;
    run_and_count(1 + (WIDTH + 2) + TAIL, -1, -1, 1'b0, 0, c);
    force_c64_one = 1'b0;
    n_tests++; if (c.done_cyc !== 1 + WIDTH + 2) begin n_fail++; $display("FAIL c64_high.done_cycle got %0d exp %0d", c.done_cyc, 1 + WIDTH + 2); end
    n_tests++; if (c.en_fw !== WIDTH) begin n_fail++; $display("FAIL c64_high.en_fw got %0d exp %0d", c.en_fw, WIDTH); end
    // co_c25 stuck high: every line collapses to one bit.
    force_c25_one = 1'b1;
    run_and_count(1 + 3 * DEPTH + TAIL, -1, -1, 1'b0, 0, c);
    force_c25_one = 1'b0;
    n_tests++; if (c.done_cyc !== 1 + 3 * DEPTH) begin n_fail++; $display("FAIL c25_high.done_cycle got %0d exp %0d", c.done_cyc, 1 + 3 * DEPTH); end
    n_tests++; if (c.en_fw !== DEPTH || c.ld_fr !== DEPTH) begin n_fail++; $display("FAIL c25_high.counts got en_fw=%0d ld_fr=%0d exp %0d", c.en_fw, c.ld_fr, DEPTH); end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    force_c25_zero = 1'b0;
    force_c25_one  = 1'b0;
    force_c64_one  = 1'b0;
    repeat (2) @(negedge clk);

    test_reset();
    test_full_run(1'b0, "full_run");
    test_back_to_back();
    test_abort(10, 7);
    repeat (3) test_abort($urandom_range(0, DEPTH - 1), $urandom_range(0, WIDTH - 1));
    test_abort_start_collision();
    test_watchdog();
    test_full_run(1'b1, "busy_start");
    test_out_of_state_carry();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
